// File: rtl/l2k_ram.sv
// l2k_ram: word RAM slave on a shared tri-state bus with a fixed number of wait states.
// Define L2K_RAM_ERR_EN to flag and suppress accesses outside the mapped address window.
module l2k_ram #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  input  logic        we,
  input  logic        ce,
  output logic        rdy,
  output logic        err
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [31:0]           wdata_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  ok_q;
  logic                  drive;
  logic [31:0]           rdata;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  cur_ok;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_ok;
  logic                  acc_we;
  logic                  enter_ack;
  logic                  unused_bits;

  // Byte offset into the window; the low two address bits never select anything.
  assign offset  = addr - BASE_ADDR;
  assign cur_idx = offset[DEPTH_LOG2+1:2];

`ifdef L2K_RAM_ERR_EN
  assign cur_ok      = (offset[31:DEPTH_LOG2+2] == '0);
  assign unused_bits = &{1'b0, offset[1:0]};
`else
  // Upper offset bits are discarded, so out-of-window addresses alias onto the array.
  assign cur_ok      = 1'b1;
  assign unused_bits = &{1'b0, offset[31:DEPTH_LOG2+2], offset[1:0]};
`endif

  // With zero wait states the ACK is entered on the capture edge itself, so the
  // access attributes come straight from the pins in IDLE and from the registers later.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    acc_idx   = idx_q;
    acc_ok    = ok_q;
    acc_we    = we_q;
    enter_ack = 1'b0;
    if (state == IDLE) begin
      acc_idx   = cur_idx;
      acc_ok    = cur_ok;
      acc_we    = we;
      enter_ack = ce && (WAIT_CYCLES == 0);
    end else if (state == WAIT) begin
      enter_ack = ce && (cnt == 4'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdy     <= 1'b0;
      err     <= 1'b0;
      drive   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
      ok_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      rdy   <= enter_ack;
      err   <= enter_ack && !acc_ok;
      drive <= enter_ack && !acc_we;
      case (state)
        IDLE: begin
          if (ce) begin
            we_q    <= we;
            wdata_q <= data;
            idx_q   <= cur_idx;
            ok_q    <= cur_ok;
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (!ce) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= ACK;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array and its read register carry no reset; contents survive rst and a
  // resettable array could not map onto block RAM. Output drive is gated by 'drive'.
  always_ff @(posedge clk) begin
    if (state == ACK && we_q && ok_q && !rst) mem[idx_q] <= wdata_q;
    if (enter_ack) rdata <= acc_ok ? mem[acc_idx] : '0;
  end

  assign data = drive ? rdata : 'z;

endmodule
